// File: rtl/booth_wallace_div_frac.sv
// Signed Q(INT_WIDTH).(FRAC_WIDTH) divider: radix-2 restoring division on magnitudes, start/done handshake.
// Optional macro FXDIV_SATURATE_EN clamps overflowed quotients instead of wrapping them.
module booth_wallace_div_frac #(
  parameter int INT_WIDTH  = 8,
  parameter int FRAC_WIDTH = 8,
  localparam int W = INT_WIDTH + FRAC_WIDTH,
  localparam int N = W + FRAC_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         div_by_zero,
  output logic         overflow,
  output logic [1:0]   fsm_state
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);
  localparam logic [N-1:0] POS_LIM = {{(N-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [N-1:0] NEG_LIM = {{(N-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] RES_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] RES_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;

  logic [W-1:0]     a_q;
  logic [W-1:0]     mag_b;
  logic             sign;
  logic [N-1:0]     dvd;
  logic [W-1:0]     rem;
  logic [CNT_W-1:0] cnt;

  logic [W:0]   shifted;
  logic         fits;
  logic [W-1:0] wrapped;
  logic [W-1:0] res_ovf;
  logic [W-1:0] res_d;
  logic         dz_d;
  logic         ovf_d;
  logic         too_big;

  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v);
    return v[W-1] ? (~v + 1'b1) : v;
  endfunction

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (b == '0) ? FIX : CALC;
      CALC: if (cnt == LAST_STEP) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // dvd doubles as the dividend shifter and the quotient collector: bits leave at the top, quotient bits enter at the bottom.
  always_comb begin
    shifted = {rem, dvd[N-1]};
    fits    = shifted >= {1'b0, mag_b};
  end

  always_comb begin
    wrapped = sign ? -dvd[W-1:0] : dvd[W-1:0];
    too_big = sign ? (dvd > NEG_LIM) : (dvd > POS_LIM);
`ifdef FXDIV_SATURATE_EN
    res_ovf = sign ? RES_MIN : RES_MAX;
`else
    res_ovf = wrapped;
`endif
    res_d = wrapped;
    dz_d  = 1'b0;
    ovf_d = 1'b0;
    if (mag_b == '0) begin
      dz_d  = 1'b1;
      res_d = (a_q == '0) ? '0 : (a_q[W-1] ? RES_MIN : RES_MAX);
    end else if (too_big) begin
      ovf_d = 1'b1;
      res_d = res_ovf;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      a_q         <= '0;
      mag_b       <= '0;
      sign        <= 1'b0;
      dvd         <= '0;
      rem         <= '0;
      cnt         <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q   <= a;
          mag_b <= magnitude(b);
          sign  <= a[W-1] ^ b[W-1];
          dvd   <= {magnitude(a), {FRAC_WIDTH{1'b0}}};
          rem   <= '0;
          cnt   <= '0;
        end
        CALC: begin
          rem <= fits ? W'(shifted - {1'b0, mag_b}) : W'(shifted);
          dvd <= {dvd[N-2:0], fits};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          result      <= res_d;
          div_by_zero <= dz_d;
          overflow    <= ovf_d;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == CALC) || (state_q == FIX);
  assign done      = (state_q == DONE);
  assign fsm_state = state_q;

endmodule
